uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/uart_tx_arb.sv | 116 +++++++++++
 tb/tb_uart_tx_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_t       : arbiter FSM state (IDLE / GRANT)
//   N_REQ_DEF         : default number of requesters
//   IDLE_TIMEOUT_DEF  : default stall limit in clk cycles (10 ms at 100 MHz)
//   CLK_HZ            : system clock frequency
//   wrap_inc()        : modulo-n increment used for the round-robin pointer
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF        = 4;
  localparam int IDLE_TIMEOUT_DEF = 1000000;
  localparam int CLK_HZ           = 100000000;

  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   i_req : request vector
//   i_ptr : highest-priority index this round
//   o_gnt : one-hot grant of the first request at or after i_ptr (wrapping)
//   o_idx : index of that grant
//   o_any : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);
  localparam int PW = $clog2(N_REQ);

  // Candidate index k = (ptr + k) mod N_REQ; one extra bit absorbs the carry
  // so non-power-of-two N_REQ wraps correctly.
  logic [N_REQ-1:0][PW-1:0] w_cand;
  logic                     w_found;

  for (genvar k = 0; k < N_REQ; k++) begin : g_cand
    logic [PW:0] w_sum;
    assign w_sum     = {1'b0, i_ptr} + (PW+1)'(k);
    assign w_cand[k] = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ))
                                                 : PW'(w_sum);
  end

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[w_cand[k]]) begin
        w_found         = 1'b1;
        o_idx           = w_cand[k];
        o_gnt[w_cand[k]] = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one uart_xmit among N_REQ
// byte streams. Grant is held for a whole packet; a stalled owner loses the
// grant after IDLE_TIMEOUT cycles without a valid byte.
//   clk100MHz, rst          : clock, synchronous active-high reset
//   req_valid/data/last/rdy : per-requester byte stream
//   tx_valid/data/rdy       : to uart_xmit
//   grant_id, busy          : current owner (0 when idle), owner present
//   timeout_err             : one-cycle pulse when a grant is revoked
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                     clk100MHz,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0][7:0]    req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_rdy,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_rdy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int            GW         = $clog2(N_REQ);
  localparam int            CW         = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] STALL_MAX  = CW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] STALL_LAST = CW'(IDLE_TIMEOUT - 1);

  arb_state_t       r_state, w_nxt;
  logic [GW-1:0]    r_rr_ptr, r_gid, w_arb_idx;
  logic [N_REQ-1:0] r_gnt, w_arb_gnt;
  logic [CW-1:0]    r_stall;
  logic             r_tout;
  logic             w_any, w_cur_valid, w_xfer, w_done, w_to;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_any)
  );

  assign w_cur_valid = req_valid[r_gid];
  assign w_xfer      = (r_state == GRANT) && w_cur_valid && tx_rdy;
  assign w_done      = w_xfer && req_last[r_gid];
  // Fires on the stall cycle whose increment brings the counter to the limit,
  // so the grant is gone the cycle the count reaches IDLE_TIMEOUT.
  assign w_to        = (r_state == GRANT) && !w_cur_valid && (r_stall == STALL_LAST);

  // State register
  always_ff @(posedge clk100MHz) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_nxt = GRANT;
      GRANT:   if (w_done || w_to) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Owner, pointer, stall counter, timeout pulse
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_gid    <= '0;
      r_gnt    <= '0;
      r_stall  <= '0;
      r_tout   <= 1'b0;
    end else begin
      r_tout <= w_to;
      if (r_state == IDLE) begin
        if (w_any) begin
          r_gid <= w_arb_idx;
          r_gnt <= w_arb_gnt;
        end
      end else if (w_done || w_to) begin
        r_rr_ptr <= GW'(wrap_inc(int'(r_gid), N_REQ));
        r_gid    <= '0;
        r_gnt    <= '0;
      end

      if (r_state == IDLE || w_xfer)
        r_stall <= '0;
      else if (!w_cur_valid && r_stall != STALL_MAX)
        r_stall <= r_stall + 1'b1;
    end
  end

  // Outputs: straight pass-through of the owner's stream during GRANT
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    req_rdy  = '0;
    busy     = 1'b0;
    if (r_state == GRANT) begin
      tx_valid = w_cur_valid;
      tx_data  = req_data[r_gid];
      req_rdy  = r_gnt & {N_REQ{tx_rdy}};
      busy     = 1'b1;
    end
  end

  assign grant_id    = r_gid;
  assign timeout_err = r_tout;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
  localparam int NR = 4;
  localparam int TO = 16;

  logic                clk100MHz = 1'b0;
  logic                rst       = 1'b1;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0][7:0]  req_data  = '0;
  logic [NR-1:0]       req_last  = '0;
  logic [NR-1:0]       req_rdy;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_rdy    = 1'b0;
  logic [1:0]          grant_id;
  logic                busy;
  logic                timeout_err;

  uart_tx_arb #(.N_REQ(NR), .IDLE_TIMEOUT(TO)) dut (
    .clk100MHz   (clk100MHz),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_rdy     (req_rdy),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk100MHz = ~clk100MHz;

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];        // bytes uart_xmit must receive, in order
  logic [8:0] src_q[NR][$];    // per requester {last, data} still to offer
  logic [NR-1:0] hs   = '0;
  logic [NR-1:0] hold = '0;
  int total = 0;
  int bad   = 0;

  // Retire source bytes accepted at the edge just passed.
  always @(posedge clk100MHz) begin
    #1;
    for (int i = 0; i < NR; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  end

  // Present queue heads (random junk when idle), then sample and score.
  always @(negedge clk100MHz) begin
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i] = 1'b1;
        req_data[i]  = src_q[i][0][7:0];
        req_last[i]  = src_q[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'($urandom);
        req_last[i]  = 1'($urandom);
      end
    end
    #1;
    hs = req_valid & req_rdy;
    if (tx_valid && tx_rdy) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got id=%0d data=%h, required no transfer", grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        if (grant_id !== e.id || tx_data !== e.d) begin
          bad++;
          $display("FAIL sb_byte: got id=%0d data=%h, required id=%0d data=%h",
                   grant_id, tx_data, e.id, e.d);
        end
        total++;
        if (req_rdy !== (4'b0001 << grant_id)) begin
          bad++;
          $display("FAIL sb_rdy: got req_rdy=%b, required %b", req_rdy, 4'b0001 << grant_id);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk100MHz);
    #2;
  endtask

  task automatic src_push(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic exp_push(input int r, input logic [7:0] d);
    exp_q.push_back('{id: 2'(r), d: d});
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending() || busy) && n < 300) begin
      step();
      n++;
    end
    ok = (n < 300);
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) step();
    total++;
    if ({tx_valid, req_rdy, busy, grant_id, timeout_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outs: got valid=%b rdy=%b busy=%b gid=%0d terr=%b, required all 0",
               tx_valid, req_rdy, busy, grant_id, timeout_err);
    end
    rst = 1'b0;
    step();
    ok = 1'b1;
  endtask

  task automatic test_contention();
    bit ok;
    tx_rdy = 1'b1;
    // rr_ptr = 0: requester 0 first
    for (int b = 0; b < 3; b++) begin
      src_push(0, 8'h01 + 8'(b), b == 2);
      src_push(3, 8'h31 + 8'(b), b == 2);
    end
    for (int b = 0; b < 3; b++) exp_push(0, 8'h01 + 8'(b));
    for (int b = 0; b < 3; b++) exp_push(3, 8'h31 + 8'(b));
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL cont_r1: left=%0d, required 0", exp_q.size()); end
    // lone packet from 0 moves rr_ptr to 1
    src_push(0, 8'h0A, 1'b1);
    exp_push(0, 8'h0A);
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL cont_mid: left=%0d, required 0", exp_q.size()); end
    // rr_ptr = 1: requester 3 first
    for (int b = 0; b < 3; b++) begin
      src_push(0, 8'h41 + 8'(b), b == 2);
      src_push(3, 8'h71 + 8'(b), b == 2);
    end
    for (int b = 0; b < 3; b++) exp_push(3, 8'h71 + 8'(b));
    for (int b = 0; b < 3; b++) exp_push(0, 8'h41 + 8'(b));
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL cont_r2: left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_single();
    bit ok;
    tx_rdy = 1'b1;
    src_push(2, 8'h55, 1'b0);
    src_push(2, 8'h33, 1'b1);
    exp_push(2, 8'h55);
    exp_push(2, 8'h33);
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL single_drain: left=%0d, required 0", exp_q.size()); end
    total++;
    if (grant_id !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got gid=%0d busy=%b, required 0 0", grant_id, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    // rr_ptr = 3 after test_single
    src_push(1, 8'h1B, 1'b1);
    src_push(3, 8'h3B, 1'b1);
    exp_push(3, 8'h3B);
    exp_push(1, 8'h1B);
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL wrap_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n, errs;
    tx_rdy = 1'b0;
    src_push(1, 8'h0F, 1'b0);
    src_push(1, 8'h00, 1'b1);
    exp_push(1, 8'h0F);
    exp_push(1, 8'h00);
    n = 0;
    while (!busy && n < 10) begin step(); n++; end
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      bad++;
      $display("FAIL bp_grant: got busy=%b gid=%0d, required 1 1", busy, grant_id);
    end
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req_rdy !== 4'b0 || tx_valid !== 1'b1 || tx_data !== 8'h0F || timeout_err !== 1'b0)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d bad cycles (rdy=%b valid=%b data=%h terr=%b), required 0",
               errs, req_rdy, tx_valid, tx_data, timeout_err);
    end
    tx_rdy = 1'b1;
    #1;
    total++;
    if (req_rdy !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release: got req_rdy=%b, required 0010", req_rdy);
    end
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL bp_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    int idle;
    tx_rdy = 1'b1;
    src_push(2, 8'hB0, 1'b0);
    src_push(2, 8'hB1, 1'b1);
    src_push(2, 8'hB2, 1'b0);
    src_push(2, 8'hB3, 1'b1);
    for (int b = 0; b < 4; b++) exp_push(2, 8'hB0 + 8'(b));
    seen = 1'b0;
    idle = 0;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      step();
      if (busy) seen = 1'b1;
      else if (seen && exp_q.size() != 0) idle++;
    end
    total++;
    if (idle != 1) begin bad++; $display("FAIL b2b_gap: got %0d idle cycles, required 1", idle); end
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL b2b_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_stall_keep();
    bit ok;
    int n, errs;
    tx_rdy = 1'b1;
    // rr_ptr = 3: requester 1 wins over 2
    src_push(1, 8'h11, 1'b0);
    src_push(1, 8'h22, 1'b0);
    src_push(1, 8'h33, 1'b1);
    src_push(2, 8'h44, 1'b1);
    exp_push(1, 8'h11);
    exp_push(1, 8'h22);
    exp_push(1, 8'h33);
    exp_push(2, 8'h44);
    n = 0;
    while (exp_q.size() > 3 && n < 20) begin step(); n++; end
    hold[1] = 1'b1;
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (busy !== 1'b1 || grant_id !== 2'd1 || tx_valid !== 1'b0 || timeout_err !== 1'b0)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_keep: %0d bad cycles (busy=%b gid=%0d valid=%b terr=%b), required 0",
               errs, busy, grant_id, tx_valid, timeout_err);
    end
    hold[1] = 1'b0;
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL stall_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    tx_rdy = 1'b1;
    src_push(1, 8'hA5, 1'b0);
    exp_push(1, 8'hA5);
    n = 0;
    while (!(busy && grant_id == 2'd1) && n < 10) begin step(); n++; end
    src_push(2, 8'h5A, 1'b1);
    exp_push(2, 8'h5A);
    n = 0;
    while (exp_q.size() > 1 && n < 10) begin step(); n++; end
    // the step that returned is just after the last transfer edge
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (timeout_err) break;
    end
    total++;
    if (n != TO) begin bad++; $display("FAIL to_delay: got pulse %0d edges after transfer, required %0d", n, TO); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got busy=%b, required 0", busy); end
    step();
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL to_next: got terr=%b busy=%b gid=%0d, required 0 1 2", timeout_err, busy, grant_id);
    end
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL to_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    tx_rdy = 1'b1;
    for (int b = 0; b < 4; b++) src_push(0, 8'hC0 + 8'(b), b == 3);
    exp_push(0, 8'hC0);
    exp_push(0, 8'hC1);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin step(); n++; end
    // byte C2 is on offer now; reset instead of sending it
    rst    = 1'b1;
    tx_rdy = 1'b0;
    step();
    total++;
    if ({tx_valid, req_rdy, busy, grant_id, timeout_err} !== 9'b0) begin
      bad++;
      $display("FAIL rmid_outs: got valid=%b rdy=%b busy=%b gid=%0d terr=%b, required all 0",
               tx_valid, req_rdy, busy, grant_id, timeout_err);
    end
    rst = 1'b0;
    src_q[0].delete();
    for (int b = 0; b < 4; b++) begin
      src_push(0, 8'hC0 + 8'(b), b == 3);
      exp_push(0, 8'hC0 + 8'(b));
    end
    tx_rdy = 1'b1;
    wait_idle(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL rmid_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_stall_keep();
    test_timeout();
    test_reset_mid();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
